vec_strided_lsu: RTL and testbench

VEC_STRIDED_LSU -- requirements
Module: vec_strided_lsu

---
 rtl/vec_strided_lsu_pkg.sv | 48 ++++
 rtl/vec_strided_lsu_if.sv | 48 ++++
 rtl/vec_strided_lsu_lane_align.sv | 30 +++
 rtl/vec_strided_lsu.sv | 179 +++++++++++++++++
 tb/tb_vec_strided_lsu.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vec_strided_lsu_pkg.sv
// Shared definitions for the strided vector load/store unit:
// SEW encodings, FSM state enum and lane/alignment helpers.
package vec_strided_lsu_pkg;

  localparam int unsigned IDX_W = 9;

  typedef enum logic [2:0] {
    SEW_8  = 3'b000,
    SEW_16 = 3'b001,
    SEW_32 = 3'b010
  } sew_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_e;

  // Byte-lane enable pattern for one element; unknown encodings act as 32b.
  function automatic logic [3:0] lane_mask(input logic [2:0] sew);
    case (sew)
      SEW_8:   lane_mask = 4'b0001;
      SEW_16:  lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Byte offset inside the word with the low address bits forced to SEW alignment.
  function automatic logic [1:0] lane_offset(input logic [2:0] sew, input logic [1:0] addr_lo);
    case (sew)
      SEW_8:   lane_offset = addr_lo;
      SEW_16:  lane_offset = {addr_lo[1], 1'b0};
      default: lane_offset = 2'b00;
    endcase
  endfunction

  // True when the element address is not a multiple of the element size.
  function automatic logic is_misaligned(input logic [2:0] sew, input logic [1:0] addr_lo);
    case (sew)
      SEW_8:   is_misaligned = 1'b0;
      SEW_16:  is_misaligned = addr_lo[0];
      default: is_misaligned = |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/vec_strided_lsu_if.sv
// Request, register-file and memory signals of the strided LSU.
// The err pulse exists only when VEC_LSU_MISALIGN_CHECK_EN is defined.
interface vec_strided_lsu_if;
  import vec_strided_lsu_pkg::*;

  logic             start;
  logic             is_store;
  logic [31:0]      base_addr;
  logic [31:0]      stride;
  logic [IDX_W-1:0] vl;
  logic [2:0]       sew;
  logic             busy;
  logic             done;
`ifdef VEC_LSU_MISALIGN_CHECK_EN
  logic             err;
`endif
  logic [IDX_W-1:0] elem_idx;
  logic [31:0]      elem_rdata;
  logic             elem_we;
  logic [31:0]      elem_wdata;
  logic             mem_valid;
  logic             mem_ready;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_wstrb;
  logic [31:0]      mem_rdata;

`ifdef VEC_LSU_MISALIGN_CHECK_EN
  modport slave (
    input  start, is_store, base_addr, stride, vl, sew, elem_rdata, mem_ready, mem_rdata,
    output busy, done, err, elem_idx, elem_we, elem_wdata, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );
  modport master (
    output start, is_store, base_addr, stride, vl, sew, elem_rdata, mem_ready, mem_rdata,
    input  busy, done, err, elem_idx, elem_we, elem_wdata, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );
`else
  modport slave (
    input  start, is_store, base_addr, stride, vl, sew, elem_rdata, mem_ready, mem_rdata,
    output busy, done, elem_idx, elem_we, elem_wdata, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );
  modport master (
    output start, is_store, base_addr, stride, vl, sew, elem_rdata, mem_ready, mem_rdata,
    input  busy, done, elem_idx, elem_we, elem_wdata, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );
`endif

endinterface

// File: rtl/vec_strided_lsu_lane_align.sv
// vec_lane_align: combinational lane shift/mask shared by loads and stores.
module vec_lane_align
  import vec_strided_lsu_pkg::*;
(
  input  logic [2:0]  i_sew,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_st_data,
  input  logic [31:0] i_ld_word,
  output logic [31:0] o_st_wdata,
  output logic [3:0]  o_st_wstrb,
  output logic [31:0] o_ld_data
);

  logic [1:0]  w_off;
  logic [4:0]  w_shamt;
  logic [3:0]  w_mask;
  logic [31:0] w_bytes;

  // Store data moves up into its lanes; load data moves down and is zero-extended.
  always_comb begin
    w_off      = lane_offset(i_sew, i_addr_lo);
    w_shamt    = {w_off, 3'b000};
    w_mask     = lane_mask(i_sew);
    w_bytes    = {{8{w_mask[3]}}, {8{w_mask[2]}}, {8{w_mask[1]}}, {8{w_mask[0]}}};
    o_st_wdata = i_st_data << w_shamt;
    o_st_wstrb = w_mask << w_off;
    o_ld_data  = (i_ld_word >> w_shamt) & w_bytes;
  end

endmodule

// File: rtl/vec_strided_lsu.sv
// Strided vector load/store unit (vlse/vsse): one word request per element.
// Define VEC_LSU_MISALIGN_CHECK_EN to abort misaligned elements with an err pulse
// instead of forcing the low address bits to SEW alignment.
module vec_strided_lsu
  import vec_strided_lsu_pkg::*;
(
  input logic              i_clk,
  input logic              i_reset,
  vec_strided_lsu_if.slave bus
);

  state_e           r_state;
  state_e           w_next;
  logic             r_is_store;
  logic [31:0]      r_stride;
  logic [31:0]      r_addr;
  logic [IDX_W-1:0] r_vl;
  logic [IDX_W-1:0] r_idx;
  logic [2:0]       r_sew;
  logic             r_busy;
  logic             r_done;
  logic [IDX_W-1:0] r_elem_idx;
  logic             r_elem_we;
  logic [31:0]      r_elem_wdata;
  logic             r_mem_valid;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic [3:0]       r_mem_wstrb;
  logic [IDX_W-1:0] w_idx_inc;
  logic             w_last;
  logic [31:0]      w_st_wdata;
  logic [3:0]       w_st_wstrb;
  logic [31:0]      w_ld_data;
`ifdef VEC_LSU_MISALIGN_CHECK_EN
  logic             r_err;
  logic             w_misaligned;

  assign w_misaligned = is_misaligned(r_sew, r_addr[1:0]);
  assign bus.err      = r_err;
`endif

  assign w_idx_inc = r_idx + 9'd1;
  assign w_last    = (w_idx_inc == r_vl);

  vec_lane_align u_align (
    .i_sew      (r_sew),
    .i_addr_lo  (r_addr[1:0]),
    .i_st_data  (bus.elem_rdata),
    .i_ld_word  (bus.mem_rdata),
    .o_st_wdata (w_st_wdata),
    .o_st_wstrb (w_st_wstrb),
    .o_ld_data  (w_ld_data)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.vl == '0)       w_next = ST_DONE;
          else if (bus.is_store)  w_next = ST_FETCH;
          else                    w_next = ST_REQ;
        end
      end
      ST_FETCH: w_next = ST_REQ;
      ST_REQ: begin
`ifdef VEC_LSU_MISALIGN_CHECK_EN
        if (w_misaligned) w_next = ST_IDLE;
        else
`endif
        w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mem_ready) begin
          if (w_last)          w_next = ST_DONE;
          else if (r_is_store) w_next = ST_FETCH;
          else                 w_next = ST_REQ;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs; pulses default low every cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_is_store   <= 1'b0;
      r_stride     <= '0;
      r_addr       <= '0;
      r_vl         <= '0;
      r_idx        <= '0;
      r_sew        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_elem_idx   <= '0;
      r_elem_we    <= 1'b0;
      r_elem_wdata <= '0;
      r_mem_valid  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wstrb  <= '0;
`ifdef VEC_LSU_MISALIGN_CHECK_EN
      r_err        <= 1'b0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_elem_we <= 1'b0;
`ifdef VEC_LSU_MISALIGN_CHECK_EN
      r_err     <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_is_store <= bus.is_store;
            r_stride   <= bus.stride;
            r_addr     <= bus.base_addr;
            r_vl       <= bus.vl;
            r_sew      <= bus.sew;
            r_idx      <= '0;
            r_elem_idx <= '0;
            r_busy     <= 1'b1;
          end
        end
        ST_REQ: begin
`ifdef VEC_LSU_MISALIGN_CHECK_EN
          if (w_misaligned) begin
            r_err  <= 1'b1;
            r_busy <= 1'b0;
          end else
`endif
          begin
            r_mem_valid <= 1'b1;
            r_mem_addr  <= {r_addr[31:2], 2'b00};
            r_mem_wdata <= r_is_store ? w_st_wdata : '0;
            r_mem_wstrb <= r_is_store ? w_st_wstrb : '0;
          end
        end
        ST_WAIT: begin
          if (bus.mem_ready) begin
            r_mem_valid <= 1'b0;
            r_idx       <= w_idx_inc;
            r_addr      <= r_addr + r_stride;
            if (!r_is_store) begin
              r_elem_we    <= 1'b1;
              r_elem_idx   <= r_idx;
              r_elem_wdata <= w_ld_data;
            end else if (!w_last) begin
              r_elem_idx   <= w_idx_inc;
            end
          end
        end
        ST_DONE: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.elem_idx   = r_elem_idx;
  assign bus.elem_we    = r_elem_we;
  assign bus.elem_wdata = r_elem_wdata;
  assign bus.mem_valid  = r_mem_valid;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.mem_wstrb  = r_mem_wstrb;

endmodule

// File: tb/tb_vec_strided_lsu.sv
// Self-checking bench for vec_strided_lsu: directed table, corner sequences and
// randomized operations checked against an arithmetic reference model.
module tb_vec_strided_lsu;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } op_t;

  typedef struct {
    logic [8:0]  idx;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    bit              st;
    logic [31:0]     base;
    logic [31:0]     stride;
    logic [8:0]      vl;
    logic [2:0]      sew;
    logic [3:0][31:0] e_addr;
    logic [3:0][31:0] e_data;
    logic [3:0]      e_wstrb;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vec_strided_lsu_if bus();

  vec_strided_lsu dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          valid_cnt = 0;
  bit          hold_mem = 1'b0;
  bit          in_req = 1'b0;
  int          lat = 0;
  op_t         cap;
  op_t         op_q[$];
  wr_t         wr_q[$];
  logic [31:0] rf [512];
  logic [31:0] mem_init [logic [29:0]];
  logic [8:0]  idx_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [29:0] w);
    if (mem_init.exists(w)) return mem_init[w];
    return ({2'b00, w} * 32'h9E3779B1) ^ 32'h3C6EF372;
  endfunction

  // Register file: read data appears one cycle after the index is presented.
  initial begin
    bus.elem_rdata = '0;
    forever begin
      @(posedge clk);
      idx_q = bus.elem_idx;
      #1 bus.elem_rdata = rf[idx_q];
    end
  end

  // Memory responder: random latency, one-cycle ready pulse, request stability check.
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom;
      end else if (bus.mem_valid && !hold_mem) begin
        if (!in_req) begin
          in_req = 1'b1;
          cap = '{addr: bus.mem_addr, wdata: bus.mem_wdata, wstrb: bus.mem_wstrb};
          lat = $urandom_range(0, 3);
        end
        if (lat == 0) begin
          check("stable_addr", bus.mem_addr, cap.addr);
          check("stable_wdata", bus.mem_wdata, cap.wdata);
          check("stable_wstrb", {28'd0, bus.mem_wstrb}, {28'd0, cap.wstrb});
          op_q.push_back(cap);
          bus.mem_rdata = mem_word(bus.mem_addr[31:2]);
          bus.mem_ready = 1'b1;
          in_req = 1'b0;
        end else begin
          lat--;
        end
      end
    end
  end

  // Event monitor.
  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.mem_valid) valid_cnt++;
    if (bus.elem_we) wr_q.push_back('{idx: bus.elem_idx, data: bus.elem_wdata});
`ifdef VEC_LSU_MISALIGN_CHECK_EN
    if (bus.err) err_cnt++;
`endif
  end

  function automatic bit end_seen();
`ifdef VEC_LSU_MISALIGN_CHECK_EN
    return bus.done || bus.err;
`else
    return bus.done;
`endif
  endfunction

  task automatic clear_obs();
    op_q.delete();
    wr_q.delete();
    done_cnt = 0;
    err_cnt = 0;
    valid_cnt = 0;
  endtask

  task automatic drive(input bit st, input logic [31:0] base, input logic [31:0] stride,
                       input logic [8:0] vl, input logic [2:0] sew);
    bus.is_store = st;
    bus.base_addr = base;
    bus.stride = stride;
    bus.vl = vl;
    bus.sew = sew;
  endtask

  task automatic wait_end(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (end_seen()) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, {31'd0, ok}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_op(input bit st, input logic [31:0] base, input logic [31:0] stride,
                        input logic [8:0] vl, input logic [2:0] sew);
    clear_obs();
    @(negedge clk);
    drive(st, base, stride, vl, sew);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_end("op_complete");
  endtask

  // Reference model: element i lives at base + i*stride, aligned down to the element size.
  task automatic compare_model(input bit st, input logic [31:0] base, input logic [31:0] stride,
                               input logic [8:0] vl, input logic [2:0] sew);
    int unsigned esz;
    check("op_count", op_q.size(), {23'd0, vl});
    check("wr_count", wr_q.size(), st ? 32'd0 : {23'd0, vl});
    check("done_count", done_cnt, 32'd1);
    esz = (sew == 3'd0) ? 1 : (sew == 3'd1) ? 2 : 4;
    for (int i = 0; i < int'(vl) && i < op_q.size(); i++) begin
      logic [31:0] a;
      logic [31:0] word;
      int unsigned off;
      logic [63:0] smask;
      logic [3:0]  strb;
      a = base + stride * 32'(i);
      word = a - (a % 4);
      off = ((a % 4) / esz) * esz;
      smask = (64'd1 << (8 * esz)) - 64'd1;
      strb = 4'(((1 << esz) - 1) << off);
      check("addr", op_q[i].addr, word);
      if (st) begin
        check("st_wdata", op_q[i].wdata, rf[i] << (8 * off));
        check("st_wstrb", {28'd0, op_q[i].wstrb}, {28'd0, strb});
      end else begin
        check("ld_wstrb", {28'd0, op_q[i].wstrb}, 32'd0);
        if (i < wr_q.size()) begin
          check("ld_idx", {23'd0, wr_q[i].idx}, 32'(i));
          check("ld_data", wr_q[i].data, 32'((mem_word(word[31:2]) >> (8 * off)) & smask));
        end
      end
    end
  endtask

  vec_t tbl[3];

  initial begin
    logic [31:0] base, stride;
    logic [8:0]  vl;
    logic [2:0]  sew;
    bit          st;
    bit          seen;

    bus.start = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    for (int i = 0; i < 512; i++) rf[i] = '0;
    mem_init[30'd100] = 32'h04030201;
    mem_init[30'd102] = 32'h0c0b0a09;
    mem_init[30'd104] = 32'h14131211;
    mem_init[30'd106] = 32'h1c1b1a19;

    tbl[0] = '{st: 1'b0, base: 32'd400, stride: 32'd8, vl: 9'd4, sew: 3'b010,
               e_addr: {32'd424, 32'd416, 32'd408, 32'd400},
               e_data: {32'h1c1b1a19, 32'h14131211, 32'h0c0b0a09, 32'h04030201},
               e_wstrb: 4'b0000};
    tbl[1] = '{st: 1'b0, base: 32'd401, stride: 32'd1, vl: 9'd3, sew: 3'b000,
               e_addr: {32'd0, 32'd400, 32'd400, 32'd400},
               e_data: {32'd0, 32'h04, 32'h03, 32'h02},
               e_wstrb: 4'b0000};
    tbl[2] = '{st: 1'b1, base: 32'd602, stride: -32'sd4, vl: 9'd2, sew: 3'b001,
               e_addr: {32'd0, 32'd0, 32'd596, 32'd600},
               e_data: {32'd0, 32'd0, 32'hcafe0000, 32'hbeef0000},
               e_wstrb: 4'b1100};

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("rst_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_elem_idx", {23'd0, bus.elem_idx}, 32'd0);
    check("rst_elem_we", {31'd0, bus.elem_we}, 32'd0);
    check("rst_elem_wdata", bus.elem_wdata, 32'd0);
`ifdef VEC_LSU_MISALIGN_CHECK_EN
    check("rst_err", {31'd0, bus.err}, 32'd0);
`endif
    reset = 1'b0;

    // Directed table.
    rf[0] = 32'h0000beef;
    rf[1] = 32'h0000cafe;
    for (int t = 0; t < 3; t++) begin
      run_op(tbl[t].st, tbl[t].base, tbl[t].stride, tbl[t].vl, tbl[t].sew);
      check("tbl_ops", op_q.size(), {23'd0, tbl[t].vl});
      check("tbl_done", done_cnt, 32'd1);
      check("tbl_writes", wr_q.size(), tbl[t].st ? 32'd0 : {23'd0, tbl[t].vl});
      for (int i = 0; i < int'(tbl[t].vl) && i < op_q.size(); i++) begin
        check("tbl_addr", op_q[i].addr, tbl[t].e_addr[i]);
        check("tbl_wstrb", {28'd0, op_q[i].wstrb}, {28'd0, tbl[t].e_wstrb});
        if (tbl[t].st) check("tbl_st_wdata", op_q[i].wdata, tbl[t].e_data[i]);
        else if (i < wr_q.size()) check("tbl_ld_data", wr_q[i].data, tbl[t].e_data[i]);
      end
    end

    // vl = 0: busy for one cycle, done in the next, no memory traffic.
    clear_obs();
    @(negedge clk);
    drive(1'b0, 32'd400, 32'd4, 9'd0, 3'b010);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("vl0_busy", {31'd0, bus.busy}, 32'd1);
    check("vl0_done_early", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    check("vl0_done", {31'd0, bus.done}, 32'd1);
    check("vl0_busy_off", {31'd0, bus.busy}, 32'd0);
    repeat (2) @(negedge clk);
    check("vl0_no_valid", valid_cnt, 32'd0);
    check("vl0_done_cnt", done_cnt, 32'd1);

    // Second start while busy is ignored.
    clear_obs();
    @(negedge clk);
    drive(1'b0, 32'd400, 32'd8, 9'd2, 3'b010);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    drive(1'b0, 32'd800, 32'd4, 9'd5, 3'b000);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_end("busy_complete");
    check("busy_ops", op_q.size(), 32'd2);
    check("busy_done", done_cnt, 32'd1);
    if (op_q.size() == 2) check("busy_addr1", op_q[1].addr, 32'd408);

`ifdef VEC_LSU_MISALIGN_CHECK_EN
    // Misaligned 32b element aborts with err and never raises mem_valid.
    clear_obs();
    run_op(1'b0, 32'd402, 32'd4, 9'd2, 3'b010);
    check("mis_err", err_cnt, 32'd1);
    check("mis_no_done", done_cnt, 32'd0);
    check("mis_no_valid", valid_cnt, 32'd0);
`endif

    // Reset while waiting on memory abandons the request.
    clear_obs();
    hold_mem = 1'b1;
    @(negedge clk);
    drive(1'b0, 32'd400, 32'd4, 9'd1, 3'b010);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.mem_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rstw_reached", {31'd0, seen}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rstw_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("rstw_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    hold_mem = 1'b0;
    in_req = 1'b0;
    done_cnt = 0;
    repeat (6) @(negedge clk);
    check("rstw_no_done", done_cnt, 32'd0);

    // Randomized operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      st = 1'($urandom_range(0, 1));
      sew = 3'($urandom_range(0, 7));
      base = $urandom;
      if ($urandom_range(0, 3) == 0) stride = $urandom;
      else stride = 32'($urandom_range(0, 128)) - 32'd64;
      vl = 9'($urandom_range(0, 6));
`ifdef VEC_LSU_MISALIGN_CHECK_EN
      if (sew == 3'd1) begin
        base[0] = 1'b0;
        stride[0] = 1'b0;
      end else if (sew != 3'd0) begin
        base[1:0] = 2'b00;
        stride[1:0] = 2'b00;
      end
`endif
      for (int i = 0; i < 8; i++) rf[i] = $urandom;
      run_op(st, base, stride, vl, sew);
      compare_model(st, base, stride, vl, sew);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
